// File: rtl/spi_pkg.sv
// Shared constants, register layout and FSM state type for the Wishbone SPI master.
package spi_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_DIV  = 2'd1;
    localparam logic [1:0] ADDR_TX   = 2'd2;
    localparam logic [1:0] ADDR_RX   = 2'd3;

    localparam int CTRL_CPHA    = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_LSB     = 2;
    localparam int CTRL_LEN_LSB = 4;
    localparam int CTRL_LEN_W   = 5;
    localparam int CTRL_CS_LSB  = 12;
    localparam int CTRL_CS_W    = 4;
    localparam int CTRL_HOLD    = 16;
    localparam int CTRL_BUSY    = 31;

    localparam logic [31:0] CTRL_MASK = 32'h0001_F1F7;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;

    // MSB-first words are moved to the top so both orders shift out from a fixed end.
    function automatic logic [31:0] tx_align(input logic [31:0] tx, input logic [4:0] len,
                                             input logic lsb);
        if (lsb) tx_align = tx;
        else     tx_align = tx << (5'd31 - len);
    endfunction

    function automatic logic [31:0] rx_align(input logic [31:0] rx, input logic [4:0] len,
                                             input logic lsb);
        if (lsb) rx_align = rx >> (5'd31 - len);
        else     rx_align = rx;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period timer: reloads from the divider captured at transfer start and
// flags leading/trailing SCK edges while the FSM is shifting.
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             shift_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             lead_o,
    output logic             trail_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             phase_q;

    // Half-period down-counter and edge-phase toggle.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= {DIV_W{1'b0}};
            cnt_q   <= {DIV_W{1'b0}};
            phase_q <= 1'b0;
        end else if (start_i) begin
            div_q   <= div_i;
            cnt_q   <= div_i;
            phase_q <= 1'b0;
        end else if (run_i) begin
            if (cnt_q == {DIV_W{1'b0}}) begin
                cnt_q <= div_q;
                if (shift_i) phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign tick_o  = run_i & (cnt_q == {DIV_W{1'b0}});
    assign lead_o  = tick_o & shift_i & ~phase_q;
    assign trail_o = tick_o & shift_i & phase_q;

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master: register decode, transfer FSM, shift registers and
// chip-select control; SCK timing comes from spi_clkgen.
module wb_spi_master
    import spi_pkg::*;
#(
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wb_cyc,
    input  logic              io_wb_stb,
    input  logic              io_wb_we,
    input  logic [1:0]        io_wb_addr,
    input  logic [31:0]       io_wb_data_in,
    output logic              io_wb_stall,
    output logic              io_wb_ack,
    output logic [31:0]       io_wb_data_out,
    output logic [NUM_CS-1:0] io_spi_cs_n,
    output logic              io_spi_sck,
    output logic              io_spi_mosi,
    input  logic              io_spi_miso,
    output logic              io_irq
);

    logic [31:0]       ctrl_q, tx_q, rxdata_q, dout_q, tx_sh_q, rx_sh_q;
    logic [DIV_W-1:0]  div_q;
    spi_state_e        state_q;
    logic              cpha_q, lsb_q, hold_q, sck_q, mosi_q, irq_q, ack_q;
    logic [4:0]        len_q;
    logic [5:0]        edge_q;
    logic [NUM_CS-1:0] cs_n_q, cs_sel_d;

    logic        busy_d, stall_d, req_d, start_d, ctrl_wr_d;
    logic        tick_d, lead_d, trail_d, drive_d, sample_d, last_edge_d;
    logic [31:0] rdata_d, init_sh_d, init_next_d, out_next_d;
    logic        init_bit_d, out_bit_d;

    assign busy_d      = (state_q != IDLE);
    assign stall_d     = busy_d & io_wb_stb & io_wb_we & (io_wb_addr == ADDR_TX);
    assign req_d       = io_wb_cyc & io_wb_stb & ~stall_d;
    assign start_d     = req_d & io_wb_we & (io_wb_addr == ADDR_TX);
    assign ctrl_wr_d   = req_d & io_wb_we & (io_wb_addr == ADDR_CTRL);
    assign drive_d     = cpha_q ? lead_d : trail_d;
    assign sample_d    = cpha_q ? trail_d : lead_d;
    assign last_edge_d = (edge_q == {len_q, 1'b1});
    assign init_sh_d   = tx_align(io_wb_data_in, ctrl_q[CTRL_LEN_LSB +: CTRL_LEN_W], ctrl_q[CTRL_LSB]);

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clock   (clock),
        .reset   (reset),
        .start_i (start_d),
        .run_i   (busy_d),
        .shift_i (state_q == SHIFT),
        .div_i   (div_q),
        .tick_o  (tick_d),
        .lead_o  (lead_d),
        .trail_o (trail_d)
    );

    // Bit selection for the first (at start) and subsequent shift-out steps.
    always_comb begin
        if (ctrl_q[CTRL_LSB]) begin
            init_bit_d  = init_sh_d[0];
            init_next_d = init_sh_d >> 1;
        end else begin
            init_bit_d  = init_sh_d[31];
            init_next_d = init_sh_d << 1;
        end
        if (lsb_q) begin
            out_bit_d  = tx_sh_q[0];
            out_next_d = tx_sh_q >> 1;
        end else begin
            out_bit_d  = tx_sh_q[31];
            out_next_d = tx_sh_q << 1;
        end
    end

    // Chip-select decode; an index beyond NUM_CS selects nothing.
    always_comb begin
        cs_sel_d = {NUM_CS{1'b1}};
        for (int i = 0; i < NUM_CS; i++) begin
            if (ctrl_q[CTRL_CS_LSB +: CTRL_CS_W] == 4'(i)) cs_sel_d[i] = 1'b0;
            else                                          cs_sel_d[i] = 1'b1;
        end
    end

    // Register read multiplexer.
    always_comb begin
        case (io_wb_addr)
            ADDR_CTRL: rdata_d = ctrl_q | {busy_d, 31'h0};
            ADDR_DIV:  rdata_d = 32'(div_q);
            ADDR_TX:   rdata_d = tx_q;
            ADDR_RX:   rdata_d = rxdata_q;
            default:   rdata_d = 32'h0;
        endcase
    end

    // Wishbone register file, acknowledge and read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q <= 32'h0;
            div_q  <= {DIV_W{1'b0}};
            tx_q   <= 32'h0;
            ack_q  <= 1'b0;
            dout_q <= 32'h0;
        end else begin
            ack_q  <= req_d;
            dout_q <= (req_d & ~io_wb_we) ? rdata_d : 32'h0;
            if (req_d & io_wb_we) begin
                case (io_wb_addr)
                    ADDR_CTRL: ctrl_q <= io_wb_data_in & CTRL_MASK;
                    ADDR_DIV:  div_q  <= io_wb_data_in[DIV_W-1:0];
                    ADDR_TX:   tx_q   <= io_wb_data_in;
                    default:   ctrl_q <= ctrl_q;
                endcase
            end
        end
    end

    // Transfer FSM with its shift registers and SPI pin registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            hold_q   <= 1'b0;
            len_q    <= 5'd0;
            edge_q   <= 6'd0;
            tx_sh_q  <= 32'h0;
            rx_sh_q  <= 32'h0;
            rxdata_q <= 32'h0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            irq_q    <= 1'b0;
            cs_n_q   <= {NUM_CS{1'b1}};
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q <= ctrl_q[CTRL_CPOL];
                    if (start_d) begin
                        state_q <= SETUP;
                        cpha_q  <= ctrl_q[CTRL_CPHA];
                        lsb_q   <= ctrl_q[CTRL_LSB];
                        hold_q  <= ctrl_q[CTRL_HOLD];
                        len_q   <= ctrl_q[CTRL_LEN_LSB +: CTRL_LEN_W];
                        edge_q  <= 6'd0;
                        rx_sh_q <= 32'h0;
                        cs_n_q  <= cs_sel_d;
                        if (ctrl_q[CTRL_CPHA]) begin
                            tx_sh_q <= init_sh_d;
                        end else begin
                            mosi_q  <= init_bit_d;
                            tx_sh_q <= init_next_d;
                        end
                    end else if (ctrl_wr_d && !io_wb_data_in[CTRL_HOLD]) begin
                        cs_n_q <= {NUM_CS{1'b1}};
                    end
                end
                SETUP: begin
                    if (tick_d) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (tick_d) begin
                        sck_q  <= ~sck_q;
                        edge_q <= edge_q + 6'd1;
                        if (drive_d) begin
                            mosi_q  <= out_bit_d;
                            tx_sh_q <= out_next_d;
                        end
                        if (sample_d) begin
                            if (lsb_q) rx_sh_q <= {io_spi_miso, rx_sh_q[31:1]};
                            else       rx_sh_q <= {rx_sh_q[30:0], io_spi_miso};
                        end
                        if (last_edge_d) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick_d) begin
                        state_q  <= IDLE;
                        irq_q    <= 1'b1;
                        rxdata_q <= rx_align(rx_sh_q, len_q, lsb_q);
                        if (!hold_q) cs_n_q <= {NUM_CS{1'b1}};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_wb_stall    = stall_d;
    assign io_wb_ack      = ack_q;
    assign io_wb_data_out = dout_q;
    assign io_spi_cs_n    = cs_n_q;
    assign io_spi_sck     = sck_q;
    assign io_spi_mosi    = mosi_q;
    assign io_irq         = irq_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// Randomised bench for wb_spi_master with a behavioural SPI slave and transfer model.
module tb_wb_spi_master;
    import spi_pkg::*;

    localparam int NUM_CS = 4;
    localparam int DIV_W  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]        addr = 2'd0;
    logic [31:0]       din = 32'h0;
    logic              io_wb_stall, io_wb_ack, io_spi_sck, io_spi_mosi, io_irq, miso;
    logic [31:0]       io_wb_data_out;
    logic [NUM_CS-1:0] io_spi_cs_n;

    int n_total = 0, n_bad = 0, cyc_cnt = 0, irq_last = 0, start_seq = 0, seen_seq = 0;
    int miso_mode = 0;

    // Slave model state: mode, word to send, and what it captured from MOSI.
    logic        s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, prev_sck = 1'b0, miso_slave = 1'b0;
    int          s_n = 1, s_bits = 0, s_edges = 0, s_out_idx = 0;
    logic [31:0] s_word = 32'h0, s_mosi_word = 32'h0;

    wb_spi_master #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .clock(clock), .reset(reset),
        .io_wb_cyc(cyc), .io_wb_stb(stb), .io_wb_we(we), .io_wb_addr(addr),
        .io_wb_data_in(din), .io_wb_stall(io_wb_stall), .io_wb_ack(io_wb_ack),
        .io_wb_data_out(io_wb_data_out), .io_spi_cs_n(io_spi_cs_n), .io_spi_sck(io_spi_sck),
        .io_spi_mosi(io_spi_mosi), .io_spi_miso(miso), .io_irq(io_irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clock) if (io_irq) irq_last <= cyc_cnt;

    assign miso = (miso_mode == 1) ? io_spi_mosi : ((miso_mode == 2) ? 1'b1 : miso_slave);

    function automatic int bit_pos(input int k);
        return s_lsb ? k : (s_n - 1 - k);
    endfunction

    function automatic logic slave_bit(input int k);
        return (k < s_n) ? s_word[bit_pos(k)] : 1'b0;
    endfunction

    // SPI slave: samples MOSI and presents MISO on the edges the mode defines.
    always @(negedge clock) begin
        if (start_seq != seen_seq) begin
            seen_seq    <= start_seq;
            s_bits      <= 0;
            s_edges     <= 0;
            s_mosi_word <= 32'h0;
            prev_sck    <= io_spi_sck;
            if (s_cpha) begin
                s_out_idx  <= 0;
                miso_slave <= 1'b0;
            end else begin
                s_out_idx  <= 1;
                miso_slave <= slave_bit(0);
            end
        end else if (io_spi_sck != prev_sck) begin
            prev_sck <= io_spi_sck;
            s_edges  <= s_edges + 1;
            if ((prev_sck == s_cpol) != s_cpha) begin
                if (s_bits < s_n) s_mosi_word[bit_pos(s_bits)] <= io_spi_mosi;
                s_bits <= s_bits + 1;
            end else begin
                miso_slave <= slave_bit(s_out_idx);
                s_out_idx  <= s_out_idx + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d, output int acc, output int ns);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; din = d;
        #1;
        ns = 0;
        while (io_wb_stall && ns < 2000) begin
            @(negedge clock); #1;
            ns++;
        end
        if (io_wb_stall) check_val("stall_timeout", io_wb_stall, 1'b0);
        acc = cyc_cnt;
        @(posedge clock); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (a == ADDR_TX) start_seq++;
        check_val("wr_ack", io_wb_ack, 1'b1);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(posedge clock); #1;
        cyc = 1'b0; stb = 1'b0;
        check_val("rd_ack", io_wb_ack, 1'b1);
        d = io_wb_data_out;
    endtask

    task automatic wait_irq(input logic [3:0] exp_cs, output int c, output logic cs_bad);
        int n;
        n = 0;
        cs_bad = 1'b0;
        do begin
            @(negedge clock);
            n++;
            if (!io_irq && io_spi_cs_n !== exp_cs) cs_bad = 1'b1;
        end while (!io_irq && n < 5000);
        if (!io_irq) check_val("irq_timeout", io_irq, 1'b1);
        c = cyc_cnt;
    endtask

    function automatic logic [3:0] cs_expect(input logic [3:0] idx);
        return (idx < 4'(NUM_CS)) ? ~(4'b0001 << idx) : 4'hF;
    endfunction

    task automatic run_xfer(input logic [31:0] ctrl, input logic [7:0] dv,
                            input logic [31:0] tx, input int mm);
        int n, acc, ns, ic, l;
        logic [31:0] mask, rd, exp_rx;
        logic [3:0]  exp_cs;
        logic        bad;
        n      = int'(ctrl[8:4]) + 1;
        mask   = 32'((64'd1 << n) - 64'd1);
        exp_cs = cs_expect(ctrl[15:12]);
        s_cpol = ctrl[1]; s_cpha = ctrl[0]; s_lsb = ctrl[2]; s_n = n;
        s_word = $urandom; miso_mode = mm;
        wb_wr(ADDR_CTRL, ctrl, acc, ns);
        wb_wr(ADDR_DIV, 32'(dv), acc, ns);
        check_val("sck_idle", io_spi_sck, ctrl[1]);
        wb_wr(ADDR_TX, tx, acc, ns);
        wait_irq(exp_cs, ic, bad);
        l = (2 * n + 2) * (int'(dv) + 1);
        check_val("irq_cycle", ic, acc + 1 + l);
        check_val("cs_during", bad, 1'b0);
        check_val("cs_after", io_spi_cs_n, ctrl[16] ? exp_cs : 4'hF);
        wb_rd(ADDR_CTRL, rd);
        check_val("irq_pulse", io_irq, 1'b0);
        check_val("ctrl_rd", rd, ctrl & 32'h0001_F1F7);
        wb_rd(ADDR_RX, rd);
        exp_rx = (mm == 1) ? (tx & mask) : ((mm == 2) ? mask : (s_word & mask));
        check_val("rxdata", rd, exp_rx);
        check_val("sck_edges", s_edges, 2 * n);
        check_val("mosi_word", s_mosi_word, tx & mask);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, c, t1, t2;
        int a1, a2, ns, ic;
        logic bad;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("rst_cs_n", io_spi_cs_n, 4'hF);
        check_val("rst_sck", io_spi_sck, 1'b0);
        check_val("rst_mosi", io_spi_mosi, 1'b0);
        check_val("rst_ack", io_wb_ack, 1'b0);
        check_val("rst_stall", io_wb_stall, 1'b0);
        check_val("rst_irq", io_irq, 1'b0);
        check_val("rst_dout", io_wb_data_out, 32'h0);
        wb_rd(ADDR_CTRL, rd); check_val("rst_ctrl", rd, 32'h0);
        wb_rd(ADDR_RX, rd);   check_val("rst_rx", rd, 32'h0);

        @(negedge clock);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = ADDR_CTRL; din = 32'h0000_0007;
        @(posedge clock); #1;
        stb = 1'b0; we = 1'b0;
        check_val("nocyc_ack", io_wb_ack, 1'b0);
        wb_rd(ADDR_CTRL, rd); check_val("nocyc_ctrl", rd, 32'h0);

        run_xfer(32'h0000_0070, 8'd1, 32'h0000_00A5, 1);
        run_xfer(32'h0000_00B7, 8'd1, 32'h0000_0123, 2);
        check_val("m3_first_bit", s_mosi_word[0], 1'b1);

        for (int i = 0; i < 12; i++) begin
            c = (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 31)) << 4)
                | 32'($urandom_range(0, 7));
            c = c | ($urandom & ~32'h0001_F1F7);
            run_xfer(c, 8'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
        end

        t1 = $urandom; t2 = $urandom;
        miso_mode = 1;
        wb_wr(ADDR_CTRL, 32'h0000_0070, a1, ns);
        wb_wr(ADDR_DIV, 32'd1, a1, ns);
        wb_wr(ADDR_TX, t1, a1, ns);
        wb_wr(ADDR_TX, t2, a2, ns);
        check_val("stall_cycles", ns, 36);
        check_val("stall_accept", a2, a1 + 37);
        check_val("irq_at_accept", irq_last, a2);
        wb_rd(ADDR_RX, rd); check_val("b2b_rx1", rd, t1 & 32'hFF);
        wait_irq(4'hE, ic, bad);
        check_val("b2b_irq2", ic, a2 + 37);
        wb_rd(ADDR_RX, rd); check_val("b2b_rx2", rd, t2 & 32'hFF);

        run_xfer(32'h0001_21F0, 8'd0, $urandom, 0);
        check_val("hold_between", io_spi_cs_n, 4'hB);
        run_xfer(32'h0001_21F0, 8'd1, $urandom, 0);
        check_val("hold_after2", io_spi_cs_n, 4'hB);
        wb_wr(ADDR_CTRL, 32'h0000_21F0, a1, ns);
        check_val("hold_release", io_spi_cs_n, 4'hF);

        miso_mode = 1;
        wb_wr(ADDR_CTRL, 32'h0000_1072, a1, ns);
        wb_wr(ADDR_DIV, 32'd3, a1, ns);
        wb_wr(ADDR_TX, 32'hFFFF_FFFF, a1, ns);
        repeat (14) @(negedge clock);
        check_val("mid_cs_n", io_spi_cs_n, 4'hD);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("mr_cs_n", io_spi_cs_n, 4'hF);
        check_val("mr_sck", io_spi_sck, 1'b0);
        check_val("mr_mosi", io_spi_mosi, 1'b0);
        check_val("mr_irq", io_irq, 1'b0);
        check_val("mr_ack", io_wb_ack, 1'b0);
        check_val("mr_dout", io_wb_data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        wb_rd(ADDR_CTRL, rd); check_val("mr_ctrl_busy", rd, 32'h0);
        wb_rd(ADDR_RX, rd);   check_val("mr_rx", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
